fphub_adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one FPHUB adder between two requesters. Each requester submits an operand pair over a valid/ready handshake. The block drives the shared adder's operand inputs, waits a parameterised adder latency, captures the sum, and returns it over a per-requester response handshake. Only one operation is in flight at a time. The block sits between the FP clients and the adder datapath.

---
 rtl/fphub_adder_arbiter.sv | 101 ++++++++++
 tb/tb_fphub_adder_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fphub_adder_arbiter.sv
// Round-robin arbiter sharing one FPHUB adder between two requesters.
// One operation in flight; result returned on a per-requester response channel.
module fphub_adder_arbiter #(
  parameter int M   = 24,
  parameter int E   = 8,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [E+M:0]   req0_x,
  input  logic [E+M:0]   req0_y,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [E+M:0]   req1_x,
  input  logic [E+M:0]   req1_y,
  output logic [E+M:0]   add_x,
  output logic [E+M:0]   add_y,
  input  logic [E+M:0]   add_z,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [E+M:0]   rsp_z,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       prio;
  logic       gnt;
  logic [3:0] cnt;
  logic       sel1;
  logic       acc;
  logic       rsp_take;

  // Requester 1 wins when alone, or when contended and favoured.
  assign sel1 = req1_valid & (~req0_valid | prio);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    acc        = 1'b0;
    rsp_take   = gnt ? rsp1_ready : rsp0_ready;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          req1_ready = sel1;
          req0_ready = req0_valid & ~sel1;
        end
        acc = req0_ready | req1_ready;
        if (acc) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      gnt   <= 1'b0;
      cnt   <= 4'd0;
      add_x <= '0;
      add_y <= '0;
      rsp_z <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        add_x <= req1_ready ? req1_x : req0_x;
        add_y <= req1_ready ? req1_y : req0_y;
        gnt   <= req1_ready;
        prio  <= ~req1_ready;
        cnt   <= 4'(LAT - 1);
      end
      if (state == WAIT) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else rsp_z <= add_z;
      end
    end
  end

  assign rsp0_valid = (state == RESP) & ~gnt;
  assign rsp1_valid = (state == RESP) & gnt;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fphub_adder_arbiter.sv
// Bench for fphub_adder_arbiter: two instances (LAT=1, LAT=5),
// directed requests, scoreboard queues checked by a response monitor.
module tb_fphub_adder_arbiter;

  localparam int W = 33;

  typedef struct packed {
    logic         ch;
    logic [W-1:0] z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic         v0 [2];
  logic         v1 [2];
  logic         r0 [2];
  logic         r1 [2];
  logic         s0v [2];
  logic         s1v [2];
  logic         s0r [2];
  logic         s1r [2];
  logic         busy [2];
  logic [W-1:0] x0 [2];
  logic [W-1:0] y0 [2];
  logic [W-1:0] x1 [2];
  logic [W-1:0] y1 [2];
  logic [W-1:0] ax [2];
  logic [W-1:0] ay [2];
  logic [W-1:0] az [2];
  logic [W-1:0] rz [2];

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed IEEE single sums for the directed vectors.
  function automatic logic [W-1:0] fadd(input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    case ({x, y})
      {33'h3F800000, 33'h40000000}: return 33'h40400000;
      {33'h3F800000, 33'h3F800000}: return 33'h40000000;
      {33'h40000000, 33'h40000000}: return 33'h40800000;
      {33'h3F000000, 33'h3E800000}: return 33'h3F400000;
      {33'h40800000, 33'h40800000}: return 33'h41000000;
      {33'h40400000, 33'h3F800000}: return 33'h40800000;
      {33'h3F800000, 33'h3F000000}: return 33'h3FC00000;
      default: return 33'h1_0BADBAD0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 5;
    fphub_adder_arbiter #(.M(24), .E(8), .LAT(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v0[g]),
      .req0_ready (r0[g]),
      .req0_x     (x0[g]),
      .req0_y     (y0[g]),
      .req1_valid (v1[g]),
      .req1_ready (r1[g]),
      .req1_x     (x1[g]),
      .req1_y     (y1[g]),
      .add_x      (ax[g]),
      .add_y      (ay[g]),
      .add_z      (az[g]),
      .rsp0_valid (s0v[g]),
      .rsp0_ready (s0r[g]),
      .rsp1_valid (s1v[g]),
      .rsp1_ready (s1r[g]),
      .rsp_z      (rz[g]),
      .busy       (busy[g])
    );
    if (L == 1) begin : g_comb
      assign az[g] = fadd(ax[g], ay[g]);
    end else begin : g_pipe
      logic [W-1:0] hist [16];
      always @(posedge clk) begin
        hist[0] <= fadd(ax[g], ay[g]);
        for (int k = 1; k < 16; k++) hist[k] <= hist[k-1];
      end
      assign az[g] = hist[L-2];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic ch, input logic [W-1:0] z);
    exp_t e;
    e.ch = ch;
    e.z  = z;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int i);
    exp_t e;
    logic ch;
    int   n;
    if (s0v[i] || s1v[i]) begin
      ch = s1v[i];
      chk($sformatf("rsp_excl%0d", i), W'(s0v[i] & s1v[i]), '0);
      n = (i == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp%0d actual ch=%0d z=%h required none",
                 i, ch, rz[i]);
      end else begin
        e = (i == 0) ? q0[0] : q1[0];
        chk($sformatf("rsp_ch%0d", i), W'(ch), W'(e.ch));
        chk($sformatf("rsp_z%0d", i), rz[i], e.z);
        if (ch ? s1r[i] : s0r[i]) begin
          if (i == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input int i, input logic ch, input logic [W-1:0] x,
                       input logic [W-1:0] y, output int ta);
    bit ok;
    ok = 0;
    ta = -1;
    if (ch) begin
      x1[i] = x; y1[i] = y; v1[i] = 1'b1;
    end else begin
      x0[i] = x; y0[i] = y; v0[i] = 1'b1;
    end
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (ch ? r1[i] : r0[i]) begin
        ok = 1;
        ta = cyc + 1;
      end
    end
    chk($sformatf("accept_to%0d_%0d", i, ch), W'(ok), W'(1));
    if (ok) begin
      @(posedge clk);
      #1;
    end
    if (ch) v1[i] = 1'b0;
    else v0[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input logic ch, input int ta,
                          input int lat);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (ch ? s1v[i] : s0v[i]) ok = 1;
    end
    chk($sformatf("rsp_to%0d", i), W'(ok), W'(1));
    if (ok) chk($sformatf("rsp_lat%0d", i), W'(cyc - ta), W'(lat));
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      if (!busy[i]) ok = 1;
    end
    chk($sformatf("idle_to%0d", i), W'(ok), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ta, tb, t0a, t0b, t1a, t1b;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b1; v1[i] = 1'b1;
      s0r[i] = 1'b1; s1r[i] = 1'b1;
      x0[i] = '0; y0[i] = '0; x1[i] = '0; y1[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", W'(r0[0]), '0);
    chk("rst_ready1", W'(r1[0]), '0);
    chk("rst_busy", W'(busy[0]), '0);
    chk("rst_add_x", ax[0], '0);
    chk("rst_rsp_z", rz[0], '0);
    chk("rst_rsp_v", W'(s0v[0] | s1v[0]), '0);
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, LAT=1
    push(0, 1'b0, 33'h40400000);
    tb = cyc;
    issue(0, 1'b0, 33'h3F800000, 33'h40000000, ta);
    chk("t1_first_cycle", W'(ta), W'(tb + 1));
    chk("t1_add_x", ax[0], 33'h3F800000);
    chk("t1_add_y", ay[0], 33'h40000000);
    chk("t1_busy", W'(busy[0]), W'(1));
    wait_rsp(0, 1'b0, ta, 1);
    wait_idle(0);

    // Contended: 0,1,0,1 spaced LAT+2
    do_reset();
    push(0, 1'b0, 33'h40000000);
    push(0, 1'b1, 33'h40800000);
    push(0, 1'b0, 33'h3F400000);
    push(0, 1'b1, 33'h41000000);
    fork
      begin
        issue(0, 1'b0, 33'h3F800000, 33'h3F800000, t0a);
        issue(0, 1'b0, 33'h3F000000, 33'h3E800000, t0b);
      end
      begin
        issue(0, 1'b1, 33'h40000000, 33'h40000000, t1a);
        issue(0, 1'b1, 33'h40800000, 33'h40800000, t1b);
      end
    join
    chk("t2_gap01", W'(t1a - t0a), W'(3));
    chk("t2_gap12", W'(t0b - t1a), W'(3));
    chk("t2_gap23", W'(t1b - t0b), W'(3));
    wait_idle(0);

    // LAT=5 with response stall on requester 1
    do_reset();
    s1r[1] = 1'b0;
    push(1, 1'b1, 33'h40800000);
    push(1, 1'b0, 33'h3FC00000);
    issue(1, 1'b1, 33'h40400000, 33'h3F800000, ta);
    x0[1] = 33'h3F800000;
    y0[1] = 33'h3F000000;
    v0[1] = 1'b1;
    wait_rsp(1, 1'b1, ta, 5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_ready0", W'(r0[1]), '0);
      chk("t3_rsp1_v", W'(s1v[1]), W'(1));
      chk("t3_rsp_z", rz[1], 33'h40800000);
    end
    @(posedge clk);
    #1;
    s1r[1] = 1'b1;
    issue(1, 1'b0, 33'h3F800000, 33'h3F000000, tb);
    wait_rsp(1, 1'b0, tb, 5);
    wait_idle(1);

    // Reset one cycle into WAIT drops the op and clears prio
    issue(1, 1'b0, 33'h40000000, 33'h40000000, ta);
    rst = 1'b1;
    x0[1] = 33'h3F800000; y0[1] = 33'h3F800000; v0[1] = 1'b1;
    x1[1] = 33'h40800000; y1[1] = 33'h40800000; v1[1] = 1'b1;
    @(negedge clk);
    chk("t4_rst_ready0", W'(r0[1]), '0);
    chk("t4_rst_ready1", W'(r1[1]), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t4_busy", W'(busy[1]), '0);
    chk("t4_add_x", ax[1], '0);
    chk("t4_add_y", ay[1], '0);
    chk("t4_rsp_z", rz[1], '0);
    chk("t4_rsp_v", W'(s0v[1] | s1v[1]), '0);
    push(1, 1'b0, 33'h40000000);
    push(1, 1'b1, 33'h41000000);
    fork
      issue(1, 1'b0, 33'h3F800000, 33'h3F800000, t0a);
      issue(1, 1'b1, 33'h40800000, 33'h40800000, t1a);
    join
    chk("t4_order", W'(t1a - t0a), W'(7));
    wait_idle(1);

    // Request operands change during WAIT
    push(1, 1'b0, 33'h3F400000);
    issue(1, 1'b0, 33'h3F000000, 33'h3E800000, ta);
    x0[1] = 33'h40800000;
    y0[1] = 33'h40800000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_add_x", ax[1], 33'h3F000000);
      chk("t5_add_y", ay[1], 33'h3E800000);
    end
    wait_rsp(1, 1'b0, ta, 5);
    wait_idle(1);

    for (int k = 0; k < 50 && (q0.size() + q1.size()) != 0; k++)
      @(negedge clk);
    chk("sb_drain", W'(q0.size() + q1.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
